// File: rtl/us_seq_pkg.sv
// -----------------------------------------------------------------------------
// us_seq_pkg
// Shared definitions for the ultrasound multi-shot sequencer:
//   - 3-bit state encoding (localparams plus the enum built from them)
//   - default PRI / DONE-timeout constants
//   - popcount helper, handy when computing expected fire totals
// -----------------------------------------------------------------------------
package us_seq_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_FIRE      = 3'd1;
   localparam logic [2:0] ST_WAIT_DONE = 3'd2;
   localparam logic [2:0] ST_PRI_WAIT  = 3'd3;
   localparam logic [2:0] ST_DRAIN     = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_FIRE      = ST_FIRE,
      S_WAIT_DONE = ST_WAIT_DONE,
      S_PRI_WAIT  = ST_PRI_WAIT,
      S_DRAIN     = ST_DRAIN
   } seq_state_t;

   // PRI of 0 means "fire again as soon as DONE falls"; timeout of 0 disables it.
   localparam logic [31:0] DEF_PRI_CYCLES     = 32'd0;
   localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd0;

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/us_next_channel.sv
// -----------------------------------------------------------------------------
// us_next_channel
// Combinational search for the next enabled channel strictly above ch_sel_i,
// wrapping to the lowest enabled channel when none is found above.
// Ports:
//   ch_mask_i  enabled-channel mask
//   ch_sel_i   current channel
//   next_ch_o  next enabled channel (wrap-around)
//   wrap_o     1 when the search wrapped (also for a single-bit mask)
// An all-zero mask returns ch_sel_i with wrap_o=1.
// -----------------------------------------------------------------------------
module us_next_channel #(
   parameter int NUM_CH   = 8,
   parameter int CH_WIDTH = 3
) (
   input  logic [NUM_CH-1:0]   ch_mask_i,
   input  logic [CH_WIDTH-1:0] ch_sel_i,
   output logic [CH_WIDTH-1:0] next_ch_o,
   output logic                wrap_o
);

   logic [NUM_CH-1:0]   above;
   logic [CH_WIDTH-1:0] low_above;
   logic [CH_WIDTH-1:0] low_mask;

   // Enabled channels strictly above the current selection.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_above
      assign above[gi] = ch_mask_i[gi] && (CH_WIDTH'(gi) > ch_sel_i);
   end

   // Scanning downward leaves the lowest set index in each result.
   always_comb begin
      low_above = ch_sel_i;
      low_mask  = ch_sel_i;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (above[i]) begin
            low_above = CH_WIDTH'(i);
         end
         if (ch_mask_i[i]) begin
            low_mask = CH_WIDTH'(i);
         end
      end
   end

   assign wrap_o    = (above == '0);
   assign next_ch_o = (above == '0) ? low_mask : low_above;

endmodule

// File: rtl/us_shot_sequencer.sv
// -----------------------------------------------------------------------------
// us_shot_sequencer
// Multi-shot scheduler above Ultrasound_FSM. Fires the FSM through its
// START/DONE handshake, sweeps CH_SEL across the enabled channels NUM_SHOTS
// times, enforces a minimum pulse-repetition interval and a per-shot DONE
// timeout.
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   SEQ_START / SEQ_ABORT       start request (rising edge) / abort (level)
//   NUM_SHOTS, CH_MASK,
//   PRI_CYCLES, TIMEOUT_CYCLES  sequence parameters, latched at accepted start
//   FSM_START / FSM_DONE        handshake with Ultrasound_FSM
//   CH_SEL, SHOT_IDX            active channel and sweep index
//   SEQ_BUSY, SEQ_DONE, SEQ_ERR status (busy level, done pulse, sticky timeout)
// All outputs are registered.
// -----------------------------------------------------------------------------
module us_shot_sequencer
   import us_seq_pkg::*;
#(
   parameter int SHOT_CNT_WIDTH = 16,
   parameter int PRI_WIDTH      = 32,
   parameter int NUM_CH         = 8,
   parameter int CH_WIDTH       = 3
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      SEQ_START,
   input  logic                      SEQ_ABORT,
   input  logic [SHOT_CNT_WIDTH-1:0] NUM_SHOTS,
   input  logic [NUM_CH-1:0]         CH_MASK,
   input  logic [PRI_WIDTH-1:0]      PRI_CYCLES,
   input  logic [PRI_WIDTH-1:0]      TIMEOUT_CYCLES,
   output logic                      FSM_START,
   input  logic                      FSM_DONE,
   output logic [CH_WIDTH-1:0]       CH_SEL,
   output logic [SHOT_CNT_WIDTH-1:0] SHOT_IDX,
   output logic                      SEQ_BUSY,
   output logic                      SEQ_DONE,
   output logic                      SEQ_ERR
);

   seq_state_t                state_q;
   logic                      start_prev_q;
   logic [SHOT_CNT_WIDTH-1:0] num_shots_q;
   logic [NUM_CH-1:0]         ch_mask_q;
   logic [PRI_WIDTH-1:0]      pri_q;
   logic [PRI_WIDTH-1:0]      timeout_q;
   logic [PRI_WIDTH-1:0]      pri_cnt_q;
   logic [PRI_WIDTH-1:0]      to_cnt_q;
   logic                      fsm_start_q;
   logic [CH_WIDTH-1:0]       ch_sel_q;
   logic [SHOT_CNT_WIDTH-1:0] shot_idx_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      err_q;

   logic [PRI_WIDTH-1:0]      pri_cnt_d;
   logic [PRI_WIDTH-1:0]      to_cnt_d;
   logic [PRI_WIDTH-1:0]      pri_thr_d;
   logic                      start_edge_d;
   logic                      last_shot_d;
   logic [NUM_CH-1:0]         nc_mask_d;
   logic [CH_WIDTH-1:0]       nc_sel_d;
   logic [CH_WIDTH-1:0]       nc_next_d;
   logic                      nc_wrap_d;

   // In IDLE the search runs on the live mask from the top channel, which
   // yields the lowest enabled channel for the first fire; otherwise it
   // advances from the current channel through the latched mask.
   assign nc_mask_d = (state_q == S_IDLE) ? CH_MASK : ch_mask_q;
   assign nc_sel_d  = (state_q == S_IDLE) ? CH_WIDTH'(NUM_CH - 1) : ch_sel_q;

   us_next_channel #(
      .NUM_CH   (NUM_CH),
      .CH_WIDTH (CH_WIDTH)
   ) u_next_channel (
      .ch_mask_i (nc_mask_d),
      .ch_sel_i  (nc_sel_d),
      .next_ch_o (nc_next_d),
      .wrap_o    (nc_wrap_d)
   );

   // Counters hold the post-increment value, so comparing the incremented
   // value makes FSM_START rising edges exactly PRI_CYCLES apart and drops
   // FSM_START exactly TIMEOUT_CYCLES after it rose.
   assign pri_cnt_d    = (pri_cnt_q == '1) ? pri_cnt_q : pri_cnt_q + PRI_WIDTH'(1);
   assign to_cnt_d     = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + PRI_WIDTH'(1);
   assign pri_thr_d    = (pri_q == '0) ? '0 : pri_q - PRI_WIDTH'(1);
   assign start_edge_d = SEQ_START & ~start_prev_q;
   assign last_shot_d  = (shot_idx_q == num_shots_q - SHOT_CNT_WIDTH'(1));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         start_prev_q <= 1'b0;
         num_shots_q  <= '0;
         ch_mask_q    <= '0;
         pri_q        <= '0;
         timeout_q    <= '0;
         pri_cnt_q    <= '0;
         to_cnt_q     <= '0;
         fsm_start_q  <= 1'b0;
         ch_sel_q     <= '0;
         shot_idx_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         start_prev_q <= SEQ_START;
         done_q       <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start_edge_d && (NUM_SHOTS != '0) && (CH_MASK != '0)) begin
                  num_shots_q <= NUM_SHOTS;
                  ch_mask_q   <= CH_MASK;
                  pri_q       <= PRI_CYCLES;
                  timeout_q   <= TIMEOUT_CYCLES;
                  err_q       <= 1'b0;
                  shot_idx_q  <= '0;
                  ch_sel_q    <= nc_next_d;
                  busy_q      <= 1'b1;
                  state_q     <= S_FIRE;
               end
            end

            S_FIRE: begin
               if (SEQ_ABORT) begin
                  fsm_start_q <= 1'b0;
                  state_q     <= S_DRAIN;
               end else begin
                  fsm_start_q <= 1'b1;
                  pri_cnt_q   <= '0;
                  to_cnt_q    <= '0;
                  state_q     <= S_WAIT_DONE;
               end
            end

            S_WAIT_DONE: begin
               pri_cnt_q <= pri_cnt_d;
               to_cnt_q  <= to_cnt_d;
               // Priority: abort, then DONE, then timeout.
               if (SEQ_ABORT) begin
                  fsm_start_q <= 1'b0;
                  state_q     <= S_DRAIN;
               end else if (FSM_DONE) begin
                  fsm_start_q <= 1'b0;
                  state_q     <= S_PRI_WAIT;
               end else if ((timeout_q != '0) && (to_cnt_d >= timeout_q)) begin
                  fsm_start_q <= 1'b0;
                  err_q       <= 1'b1;
                  state_q     <= S_DRAIN;
               end
            end

            S_PRI_WAIT: begin
               pri_cnt_q <= pri_cnt_d;
               if (SEQ_ABORT) begin
                  state_q <= S_DRAIN;
               end else if (!FSM_DONE && (pri_cnt_d >= pri_thr_d)) begin
                  if (nc_wrap_d && last_shot_d) begin
                     // Final sweep complete; CH_SEL/SHOT_IDX keep their last values.
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     ch_sel_q <= nc_next_d;
                     if (nc_wrap_d) begin
                        shot_idx_q <= shot_idx_q + SHOT_CNT_WIDTH'(1);
                     end
                     state_q <= S_FIRE;
                  end
               end
            end

            S_DRAIN: begin
               // Wait for the FSM to release DONE; only a timeout end reports done.
               if (!FSM_DONE) begin
                  done_q  <= err_q;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end

            default: begin
               fsm_start_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign FSM_START = fsm_start_q;
   assign CH_SEL    = ch_sel_q;
   assign SHOT_IDX  = shot_idx_q;
   assign SEQ_BUSY  = busy_q;
   assign SEQ_DONE  = done_q;
   assign SEQ_ERR   = err_q;

endmodule

// File: tb/tb_us_shot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_us_shot_sequencer
// Table of sequence records plus hand-written corner-case sequences. A small
// Ultrasound_FSM model answers FSM_START with DONE after a programmable delay.
// -----------------------------------------------------------------------------
module tb_us_shot_sequencer;
   import us_seq_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        SEQ_START;
   logic        SEQ_ABORT;
   logic [15:0] NUM_SHOTS;
   logic [7:0]  CH_MASK;
   logic [31:0] PRI_CYCLES;
   logic [31:0] TIMEOUT_CYCLES;
   logic        FSM_START;
   logic        FSM_DONE = 1'b0;
   logic [2:0]  CH_SEL;
   logic [15:0] SHOT_IDX;
   logic        SEQ_BUSY;
   logic        SEQ_DONE;
   logic        SEQ_ERR;

   us_shot_sequencer #(
      .SHOT_CNT_WIDTH (16),
      .PRI_WIDTH      (32),
      .NUM_CH         (8),
      .CH_WIDTH       (3)
   ) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .SEQ_START      (SEQ_START),
      .SEQ_ABORT      (SEQ_ABORT),
      .NUM_SHOTS      (NUM_SHOTS),
      .CH_MASK        (CH_MASK),
      .PRI_CYCLES     (PRI_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .FSM_START      (FSM_START),
      .FSM_DONE       (FSM_DONE),
      .CH_SEL         (CH_SEL),
      .SHOT_IDX       (SHOT_IDX),
      .SEQ_BUSY       (SEQ_BUSY),
      .SEQ_DONE       (SEQ_DONE),
      .SEQ_ERR        (SEQ_ERR)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- Ultrasound_FSM model ----------------
   // DONE rises once START has been high for done_delay cycles (0 = never),
   // and is held done_hold cycles after START falls.
   int done_delay = 0;
   int done_hold  = 0;
   int hi_cnt     = 0;
   int hold_cnt   = 0;

   always @(negedge CLK) begin
      if (RESET) begin
         FSM_DONE = 1'b0;
         hi_cnt   = 0;
         hold_cnt = 0;
      end else if (FSM_START) begin
         hi_cnt++;
         hold_cnt = 0;
         if (done_delay != 0 && hi_cnt >= done_delay) FSM_DONE = 1'b1;
      end else begin
         hi_cnt = 0;
         if (FSM_DONE && hold_cnt < done_hold) begin
            hold_cnt++;
         end else begin
            FSM_DONE = 1'b0;
            hold_cnt = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   int   cyc = 0;
   int   rise_cyc[$];
   int   rise_ch[$];
   int   rise_idx[$];
   int   rise_err[$];
   int   hi_len[$];
   int   done_cycles = 0;
   int   busy_cycles = 0;
   int   cur_len = 0;
   logic prev_start = 1'b0;

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      if (FSM_START && !prev_start) begin
         rise_cyc.push_back(cyc);
         rise_ch.push_back(int'(CH_SEL));
         rise_idx.push_back(int'(SHOT_IDX));
         rise_err.push_back(int'(SEQ_ERR));
         cur_len = 0;
      end
      if (FSM_START) cur_len++;
      if (!FSM_START && prev_start) hi_len.push_back(cur_len);
      if (SEQ_DONE) done_cycles++;
      if (SEQ_BUSY) busy_cycles++;
      prev_start = FSM_START;
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] shots;
      logic [7:0]  mask;
      logic [31:0] pri;
      logic [31:0] tmo;
      int          delay;
      int          exp_fires;
      int          exp_done;
      int          exp_err;
      int          exp_first_ch;
      int          exp_last_ch;
      int          exp_last_idx;
      int          exp_hi_len;
   } vec_t;

   vec_t vecs[8];

   task automatic wait_idle(input string name);
      int bound;
      bound = 0;
      while (SEQ_BUSY && bound < 5000) begin
         @(negedge CLK);
         bound++;
      end
      check({name, "_idle_bound"}, longint'(bound < 5000), 1);
   endtask

   task automatic run_vec(input int v, output int r0);
      int h0, d0, b0, nf;
      string nm;
      nm = $sformatf("v%0d", v);
      @(negedge CLK);
      NUM_SHOTS      = vecs[v].shots;
      CH_MASK        = vecs[v].mask;
      PRI_CYCLES     = vecs[v].pri;
      TIMEOUT_CYCLES = vecs[v].tmo;
      done_delay     = vecs[v].delay;
      done_hold      = 0;
      r0 = rise_cyc.size();
      h0 = hi_len.size();
      d0 = done_cycles;
      b0 = busy_cycles;
      SEQ_START = 1'b1;
      @(negedge CLK);
      SEQ_START = 1'b0;
      repeat (3) @(negedge CLK);
      wait_idle(nm);
      repeat (2) @(negedge CLK);
      nf = rise_cyc.size() - r0;
      check({nm, "_fires"}, nf, vecs[v].exp_fires);
      check({nm, "_done_pulse_cycles"}, done_cycles - d0, vecs[v].exp_done);
      check({nm, "_seq_err"}, SEQ_ERR, vecs[v].exp_err);
      check({nm, "_busy_seen"}, longint'((busy_cycles - b0) != 0),
            longint'(vecs[v].exp_fires != 0));
      if (nf > 0) begin
         check({nm, "_first_ch"}, rise_ch[r0], vecs[v].exp_first_ch);
         check({nm, "_err_at_first_fire"}, rise_err[r0], 0);
         check({nm, "_last_ch"}, rise_ch[rise_cyc.size()-1], vecs[v].exp_last_ch);
         check({nm, "_last_idx"}, rise_idx[rise_cyc.size()-1], vecs[v].exp_last_idx);
      end
      if (vecs[v].exp_hi_len != 0 && hi_len.size() > h0) begin
         check({nm, "_start_high_len"}, hi_len[h0], vecs[v].exp_hi_len);
      end
   endtask

   initial begin
      int r0, d0, b0, bound;
      int exp_ch[6];
      int exp_idx[6];
      exp_ch  = '{2, 5, 7, 2, 5, 7};
      exp_idx = '{0, 0, 0, 1, 1, 1};

      //          shots  mask   pri     tmo    dly fires done err first last idx hi
      vecs[0] = '{16'd1, 8'h01, 32'd0,   32'd0,  20, 1, 1, 0, 0, 0, 0, 20};
      vecs[1] = '{16'd2, 8'hA4, 32'd100, 32'd0,  20, 6, 1, 0, 2, 7, 1, 20};
      vecs[2] = '{16'd1, 8'h01, 32'd0,   32'd50, 0,  1, 1, 1, 0, 0, 0, 50};
      vecs[3] = '{16'd0, 8'hFF, 32'd0,   32'd0,  5,  0, 0, 1, 0, 0, 0, 0};
      vecs[4] = '{16'd3, 8'h00, 32'd0,   32'd0,  5,  0, 0, 1, 0, 0, 0, 0};
      vecs[5] = '{16'd3, 8'h81, 32'd0,   32'd0,  3,  6, 1, 0, 0, 7, 2, 3};
      vecs[6] = '{16'd1, 8'h11, 32'd0,   32'd8,  8,  2, 1, 0, 0, 4, 0, 8};
      vecs[7] = '{16'd2, 8'h08, 32'd0,   32'd8,  9,  1, 1, 1, 3, 3, 0, 8};

      RESET = 1'b1;
      SEQ_START = 1'b0;
      SEQ_ABORT = 1'b0;
      NUM_SHOTS = '0;
      CH_MASK = '0;
      PRI_CYCLES = '0;
      TIMEOUT_CYCLES = '0;
      repeat (3) @(negedge CLK);
      check("reset_outputs", {FSM_START, CH_SEL, SHOT_IDX, SEQ_BUSY, SEQ_DONE, SEQ_ERR}, 0);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);

      for (int v = 0; v < 8; v++) begin
         run_vec(v, r0);
         $display("vector %0d: shots=%0d mask=%h pri=%0d tmo=%0d fires=%0d err=%0d",
                  v, vecs[v].shots, vecs[v].mask, vecs[v].pri, vecs[v].tmo,
                  rise_cyc.size() - r0, SEQ_ERR);
         if (v == 1 && rise_cyc.size() - r0 == 6) begin
            for (int i = 0; i < 6; i++) begin
               check($sformatf("sweep_ch_%0d", i), rise_ch[r0+i], exp_ch[i]);
               check($sformatf("sweep_idx_%0d", i), rise_idx[r0+i], exp_idx[i]);
            end
            for (int i = 0; i < 5; i++) begin
               check($sformatf("sweep_pri_gap_%0d", i), rise_cyc[r0+i+1] - rise_cyc[r0+i], 100);
            end
         end
      end

      // Start latency; SEQ_ERR (set by vector 7) clears on the accepted start.
      @(negedge CLK);
      NUM_SHOTS = 16'd1; CH_MASK = 8'h02; PRI_CYCLES = 0; TIMEOUT_CYCLES = 0;
      done_delay = 4;
      SEQ_START = 1'b1;
      @(negedge CLK);
      check("lat_busy_after_k", SEQ_BUSY, 1);
      check("lat_start_after_k", FSM_START, 0);
      check("lat_err_cleared", SEQ_ERR, 0);
      SEQ_START = 1'b0;
      @(negedge CLK);
      check("lat_start_after_k1", FSM_START, 1);
      check("lat_ch_sel", CH_SEL, 1);
      wait_idle("lat");
      $display("latency sequence: ch_sel=%0d", rise_ch[rise_cyc.size()-1]);

      // SEQ_START held high 500 cycles; input changes while busy ignored.
      @(negedge CLK);
      NUM_SHOTS = 16'd1; CH_MASK = 8'h01; done_delay = 5;
      r0 = rise_cyc.size(); d0 = done_cycles;
      SEQ_START = 1'b1;
      @(negedge CLK);
      NUM_SHOTS = 16'd5; CH_MASK = 8'hFF;
      repeat (499) @(negedge CLK);
      SEQ_START = 1'b0;
      repeat (3) @(negedge CLK);
      wait_idle("held");
      check("held_fires", rise_cyc.size() - r0, 1);
      check("held_done_pulse_cycles", done_cycles - d0, 1);
      $display("held-start sequence: fires=%0d", rise_cyc.size() - r0);

      // Abort coincident with DONE, 10 cycles into WAIT_DONE; DONE held 5 more.
      @(negedge CLK);
      NUM_SHOTS = 16'd3; CH_MASK = 8'h0F; done_delay = 10; done_hold = 5;
      r0 = rise_cyc.size(); d0 = done_cycles;
      SEQ_START = 1'b1;
      @(negedge CLK);
      SEQ_START = 1'b0;
      bound = 0;
      while (!FSM_START && bound < 20) begin @(negedge CLK); bound++; end
      check("abort_fire_bound", longint'(bound < 20), 1);
      repeat (9) @(negedge CLK);
      SEQ_ABORT = 1'b1;
      @(negedge CLK);
      SEQ_ABORT = 1'b0;
      check("abort_start_low", FSM_START, 0);
      check("abort_busy_drain", SEQ_BUSY, 1);
      repeat (3) @(negedge CLK);
      check("abort_still_drain", SEQ_BUSY, 1);
      wait_idle("abort");
      repeat (2) @(negedge CLK);
      check("abort_fires", rise_cyc.size() - r0, 1);
      check("abort_no_done", done_cycles - d0, 0);
      check("abort_no_err", SEQ_ERR, 0);
      done_hold = 0;
      $display("abort sequence: fires=%0d done=%0d", rise_cyc.size() - r0, done_cycles - d0);

      // Reset in the middle of PRI_WAIT.
      @(negedge CLK);
      NUM_SHOTS = 16'd2; CH_MASK = 8'h0C; PRI_CYCLES = 32'd20; done_delay = 3;
      r0 = rise_cyc.size(); d0 = done_cycles; b0 = 0;
      SEQ_START = 1'b1;
      @(negedge CLK);
      SEQ_START = 1'b0;
      while (!((rise_cyc.size() - r0 == 3) && !FSM_START) && b0 < 500) begin
         @(negedge CLK);
         b0++;
      end
      check("rst_reach_bound", longint'(b0 < 500), 1);
      check("rst_pre_shot_idx", SHOT_IDX, 1);
      check("rst_pre_ch_sel", CH_SEL, 2);
      RESET = 1'b1;
      @(negedge CLK);
      check("rst_mid_outputs", {FSM_START, CH_SEL, SHOT_IDX, SEQ_BUSY, SEQ_DONE, SEQ_ERR}, 0);
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_no_done", done_cycles - d0, 0);
      check("rst_stays_idle", SEQ_BUSY, 0);
      $display("reset sequence: fires before reset=%0d", rise_cyc.size() - r0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
